// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing / test-pattern block.
//   mode_e        pattern select encodings (bars, grey ramp, grid, external pixel)
//   BAR_*         the eight colour-bar values, left to right
//   SVGA_*/VGA_*  800x600@60 and 640x480@60 timing presets
//   bar_colour()  bar index -> 24-bit RGB
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_RAMP = 2'd1,
    MODE_GRID = 2'd2,
    MODE_EXT  = 2'd3
  } mode_e;

  localparam logic [23:0] BAR_BLACK   = 24'h000000;
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;
  localparam bit          SVGA_HS_POL   = 1'b1;
  localparam bit          SVGA_VS_POL   = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam bit          VGA_HS_POL    = 1'b0;
  localparam bit          VGA_VS_POL    = 1'b0;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0: c = BAR_BLACK;
      3'd1: c = BAR_WHITE;
      3'd2: c = BAR_MAGENTA;
      3'd3: c = BAR_RED;
      3'd4: c = BAR_GREEN;
      3'd5: c = BAR_BLUE;
      3'd6: c = BAR_YELLOW;
      3'd7: c = BAR_CYAN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_tpg.sv
// vga_tpg: registered test-pattern generator (one cycle latency).
// Only instantiated when VGA_TPG_EN is defined.
// Ports:
//   pixel_clock  clock
//   reset_n      synchronous active-low reset
//   x, y         pixel coordinate (CNT_W bits, CNT_W >= 8)
//   mode         pattern select (MODE_EXT yields black; the top muxes rgb_in)
//   rgb          registered 24-bit pattern colour
module vga_tpg
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  mode_e            mode,
  output logic [23:0]      rgb
);

  localparam int unsigned      BAR_W  = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  logic [2:0]  bar_idx;
  logic        grid_on;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  // Bar index by threshold count, so leftover pixels stay in the last bar.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  always_comb begin
    grid_on = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == X_LAST) || (y == Y_LAST);
  end

  always_comb begin
    rgb_d = '0;
    unique case (mode)
      MODE_BARS: rgb_d = bar_colour(bar_idx);
      MODE_RAMP: rgb_d = {x[7:0], x[7:0], x[7:0]};
      MODE_GRID: rgb_d = grid_on ? BAR_WHITE : BAR_BLACK;
      MODE_EXT:  rgb_d = '0;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule

// File: rtl/vga_timing_tpg.sv
// vga_timing_tpg: programmable VGA raster timing with frame-synchronous pattern mux.
// Build option: define VGA_TPG_EN to include the internal pattern generator (modes
// bars/ramp/grid/external); without it the mode port is ignored and rgb passes rgb_in.
// Pipeline: S0 counters -> S1 pixel request (pix_req/pix_x/pix_y) -> S2 video
// (hs/vs/de/blank/sof/rgb). An external source answers pix_req with rgb_in on the
// following cycle, which lines up with de.
// Ports:
//   pixel_clock          sole clock
//   reset_n              synchronous active-low reset
//   timing_en            run enable; low parks the raster at the frame origin
//   mode[1:0]            pattern select, taken at frame start
//   rgb_in[23:0]         external pixel, valid the cycle after pix_req
//   pix_req, pix_x/y     pixel request and its coordinate, one cycle ahead of de
//   hs, vs               syncs with HS_POL/VS_POL polarity
//   de, blank            data enable and its inverse
//   sof                  start-of-frame pulse on the first de of a frame
//   frame_cnt[7:0]       completed-frame counter
//   rgb[23:0]            pixel out, zero outside de
module vga_timing_tpg
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned H_FP     = SVGA_H_FP,
  parameter int unsigned H_SYNC   = SVGA_H_SYNC,
  parameter int unsigned H_BP     = SVGA_H_BP,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned V_FP     = SVGA_V_FP,
  parameter int unsigned V_SYNC   = SVGA_V_SYNC,
  parameter int unsigned V_BP     = SVGA_V_BP,
  parameter bit          HS_POL   = SVGA_HS_POL,
  parameter bit          VS_POL   = SVGA_VS_POL,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic             timing_en,
  input  logic [1:0]       mode,
  input  logic [23:0]      rgb_in,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             blank,
  output logic             sof,
  output logic [7:0]       frame_cnt,
  output logic [23:0]      rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);

  // S0: raster counters and region decode
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_last, v_last, frame_wrap;
  logic             s0_active, s0_hsync, s0_vsync, s0_origin;

  // S1: pixel request
  logic             req_q, hsync1_q, vsync1_q, sof1_q;
  logic [CNT_W-1:0] x_q, y_q;

  // S2: video timing
  logic             de_q, hs_q, vs_q, sof_q;
  logic [7:0]       frame_cnt_q;

  always_comb begin
    h_last     = (h_cnt_q == H_LAST_C);
    v_last     = (v_cnt_q == V_LAST_C);
    frame_wrap = timing_en && h_last && v_last;
    s0_active  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    s0_hsync   = (h_cnt_q >= HS_START_C) && (h_cnt_q < HS_END_C);
    s0_vsync   = (v_cnt_q >= VS_START_C) && (v_cnt_q < VS_END_C);
    s0_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // A disabled raster parks at the origin, so enabling always starts a fresh frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!timing_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n || !timing_en) begin
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync1_q <= 1'b0;
      vsync1_q <= 1'b0;
      sof1_q   <= 1'b0;
    end else begin
      req_q    <= s0_active;
      x_q      <= h_cnt_q;
      y_q      <= v_cnt_q;
      hsync1_q <= s0_hsync;
      vsync1_q <= s0_vsync;
      sof1_q   <= s0_origin;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n || !timing_en) begin
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      sof_q <= 1'b0;
    end else begin
      de_q  <= req_q;
      hs_q  <= hsync1_q ? HS_POL : ~HS_POL;
      vs_q  <= vsync1_q ? VS_POL : ~VS_POL;
      sof_q <= sof1_q;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n)        frame_cnt_q <= '0;
    else if (frame_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

`ifdef VGA_TPG_EN
  mode_e       mode_q;
  logic [23:0] pat_rgb;

  // Taken only at the origin so a frame never mixes two patterns.
  always_ff @(posedge pixel_clock) begin
    if (!reset_n)                    mode_q <= MODE_BARS;
    else if (timing_en && s0_origin) mode_q <= mode_e'(mode);
  end

  vga_tpg #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_tpg (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .x           (x_q),
    .y           (y_q),
    .mode        (mode_q),
    .rgb         (pat_rgb)
  );

  // rgb_in answers last cycle's request, so it is muxed in unregistered to align with de.
  always_comb begin
    rgb = '0;
    if (de_q) rgb = (mode_q == MODE_EXT) ? rgb_in : pat_rgb;
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;

  always_comb begin
    rgb = '0;
    if (de_q) rgb = rgb_in;
  end
`endif

  assign pix_req   = req_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign de        = de_q;
  assign blank     = ~de_q;
  assign sof       = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule
